// File: rtl/pipeline_flow_ctrl_pkg.sv
// ============================================================================
// Module : pipeline_flow_ctrl_pkg
// Brief  : Shared types and constants for the LC-3b pipeline flow controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_IHOLD = 2'd1,
        S_DWAIT = 2'd2
    } lc3b_flow_state;

    localparam logic [15:0] c_NOP = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/pipeline_flow_ctrl_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_flow_ctrl.sv
// ============================================================================
// Module : pipeline_flow_ctrl
// Brief  : Converts hazard requests and I/D memory handshakes into per-stage
//          load / bubble strobes for the 5-stage LC-3b pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_flow_ctrl
    import pipeline_flow_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gen_bubble,
    input  logic             squash_ID,
    input  logic             dmem_req,
    input  logic             imem_resp,
    input  logic             dmem_resp,
    output logic             imem_read,
    output logic             dmem_go,
    output logic             load_pc,
    output logic             load_if_buf,
    output logic             load_IF_ID,
    output logic             load_ID_EX,
    output logic             nop_ID_EX,
    output logic             load_EX_MEM,
    output logic             load_MEM_WB,
    output logic             flow_ID_EX,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    lc3b_flow_state r_state;
    lc3b_flow_state w_state_nxt;
    logic           r_squash_pend;

    logic w_fetch_held;
    logic w_if_done;
    logic w_istall;
    logic w_dstall;
    logic w_squash_eff;

    assign w_fetch_held = (r_state == S_IHOLD);
    assign w_if_done    = w_fetch_held | imem_resp;
    assign w_istall     = !w_if_done;
    assign w_dstall     = dmem_req & !dmem_resp;
    assign w_squash_eff = squash_ID | r_squash_pend;

    always_comb begin
        imem_read   = !w_fetch_held;
        dmem_go     = dmem_req;
        load_if_buf = imem_resp;
        load_pc     = 1'b0;
        load_IF_ID  = 1'b0;
        load_ID_EX  = 1'b0;
        nop_ID_EX   = 1'b0;
        load_EX_MEM = 1'b0;
        load_MEM_WB = 1'b0;

        if (w_dstall) begin
            // Whole pipe frozen; only the fetch port may still complete.
            load_pc = 1'b0;
        end else if (w_istall) begin
            load_ID_EX  = 1'b1;
            nop_ID_EX   = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
        end else if (w_squash_eff) begin
            load_pc     = 1'b1;
            load_IF_ID  = 1'b1;
            load_ID_EX  = 1'b1;
            nop_ID_EX   = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
        end else if (gen_bubble) begin
            load_ID_EX  = 1'b1;
            nop_ID_EX   = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
        end else begin
            load_pc     = 1'b1;
            load_IF_ID  = 1'b1;
            load_ID_EX  = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
        end
    end

    assign flow_ID_EX = load_ID_EX;

    // A fetch that completes while memory stalls parks in S_IHOLD so it is
    // never refetched; S_DWAIT therefore means both ports are outstanding.
    always_comb begin
        w_state_nxt = r_state;
        if (w_dstall) begin
            w_state_nxt = w_if_done ? S_IHOLD : S_DWAIT;
        end else if (load_IF_ID) begin
            w_state_nxt = S_RUN;
        end else if (w_if_done) begin
            w_state_nxt = S_IHOLD;
        end else begin
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_squash_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (flow_ID_EX) begin
                r_squash_pend <= 1'b0;
            end else if (squash_ID) begin
                r_squash_pend <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_dstall | w_istall),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (nop_ID_EX & flow_ID_EX),
        .count (bubble_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_flow_ctrl.sv
// ============================================================================
// Module : tb_pipeline_flow_ctrl
// Brief  : Directed + random bench for pipeline_flow_ctrl against a
//          rule-level reference model; a narrow-counter copy checks saturation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_flow_ctrl;

    logic clk;
    logic reset;
    logic gen_bubble, squash_ID, dmem_req, imem_resp, dmem_resp;

    logic        imem_read, dmem_go, load_pc, load_if_buf, load_IF_ID;
    logic        load_ID_EX, nop_ID_EX, load_EX_MEM, load_MEM_WB, flow_ID_EX;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        n_imem_read, n_dmem_go, n_load_pc, n_load_if_buf, n_load_IF_ID;
    logic        n_load_ID_EX, n_nop_ID_EX, n_load_EX_MEM, n_load_MEM_WB, n_flow_ID_EX;
    logic [1:0]  n_stall_cnt, n_bubble_cnt;

    pipeline_flow_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .gen_bubble(gen_bubble), .squash_ID(squash_ID),
        .dmem_req(dmem_req), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .imem_read(imem_read), .dmem_go(dmem_go), .load_pc(load_pc),
        .load_if_buf(load_if_buf), .load_IF_ID(load_IF_ID), .load_ID_EX(load_ID_EX),
        .nop_ID_EX(nop_ID_EX), .load_EX_MEM(load_EX_MEM), .load_MEM_WB(load_MEM_WB),
        .flow_ID_EX(flow_ID_EX), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipeline_flow_ctrl #(.CNT_W(2)) dut_n (
        .clk(clk), .reset(reset), .gen_bubble(gen_bubble), .squash_ID(squash_ID),
        .dmem_req(dmem_req), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .imem_read(n_imem_read), .dmem_go(n_dmem_go), .load_pc(n_load_pc),
        .load_if_buf(n_load_if_buf), .load_IF_ID(n_load_IF_ID), .load_ID_EX(n_load_ID_EX),
        .nop_ID_EX(n_nop_ID_EX), .load_EX_MEM(n_load_EX_MEM), .load_MEM_WB(n_load_MEM_WB),
        .flow_ID_EX(n_flow_ID_EX), .stall_cnt(n_stall_cnt), .bubble_cnt(n_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: a fetched word is either held or not, a data access
    // either keeps the pipe frozen or not, and a squash may be waiting.
    bit m_held, m_dwait, m_pend;
    int m_stalls, m_bubbles;

    function automatic logic [31:0] sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [31:0] dut_vec();
        return {22'b0, imem_read, dmem_go, load_pc, load_if_buf, load_IF_ID,
                load_ID_EX, nop_ID_EX, load_EX_MEM, load_MEM_WB, flow_ID_EX};
    endfunction

    function automatic logic [31:0] dut_n_vec();
        return {22'b0, n_imem_read, n_dmem_go, n_load_pc, n_load_if_buf, n_load_IF_ID,
                n_load_ID_EX, n_nop_ID_EX, n_load_EX_MEM, n_load_MEM_WB, n_flow_ID_EX};
    endfunction

    task automatic model_reset();
        m_held = 0; m_dwait = 0; m_pend = 0; m_stalls = 0; m_bubbles = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_state"}, 32'(dut.r_state), m_held ? 1 : (m_dwait ? 2 : 0));
        check({tag, "_pend"}, 32'(dut.r_squash_pend), 32'(m_pend));
        check({tag, "_stall"}, 32'(stall_cnt), sat(m_stalls, 16));
        check({tag, "_bubble"}, 32'(bubble_cnt), sat(m_bubbles, 16));
        check({tag, "_stall_n"}, 32'(n_stall_cnt), sat(m_stalls, 2));
        check({tag, "_bubble_n"}, 32'(n_bubble_cnt), sat(m_bubbles, 2));
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic step(input string tag, input bit gb, input bit sq, input bit dreq,
                        input bit iresp, input bit dresp);
        bit if_done, istall, dstall, pc, ifid, idex, nop, exmem, memwb;
        logic [31:0] exp;
        gen_bubble = gb; squash_ID = sq; dmem_req = dreq;
        imem_resp = iresp; dmem_resp = dresp;
        #2;
        if_done = m_held || iresp;
        istall  = !if_done;
        dstall  = dreq && !dresp;
        {pc, ifid, idex, nop, exmem, memwb} = '0;
        if (dstall) begin
        end else if (istall) begin
            {idex, nop, exmem, memwb} = 4'b1111;
        end else if (sq || m_pend) begin
            {pc, ifid, idex, nop, exmem, memwb} = 6'b111111;
        end else if (gb) begin
            {idex, nop, exmem, memwb} = 4'b1111;
        end else begin
            {pc, ifid, idex, exmem, memwb} = 5'b11111;
        end
        exp = {22'b0, !m_held, dreq, pc, iresp, ifid, idex, nop, exmem, memwb, idex};
        check_state(tag);
        check({tag, "_strobes"}, dut_vec(), exp);
        check({tag, "_strobes_n"}, dut_n_vec(), exp);
        @(posedge clk);
        if (dstall || istall) m_stalls++;
        if (nop && idex) m_bubbles++;
        m_pend  = idex ? 0 : (sq ? 1 : m_pend);
        m_held  = if_done && !ifid;
        m_dwait = dstall && !if_done;
        #1;
    endtask

    // Reset asserted between edges; the async path must act immediately.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_state(tag);
        check({tag, "_imem_read"}, 32'(imem_read), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {gen_bubble, squash_ID, dmem_req, imem_resp, dmem_resp} = '0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        check_state("por");
        check("por_imem_read", 32'(imem_read), 1);

        // Reset while waiting on data memory with a squash outstanding
        step("t1a", 0, 1, 1, 0, 0);
        check("t1_pre_state", 32'(dut.r_state), 2);
        check("t1_pre_pend", 32'(dut.r_squash_pend), 1);
        async_reset("t1");

        // Single gen_bubble with no stalls
        step("t2a", 0, 0, 0, 1, 0);
        step("t2b", 1, 0, 0, 1, 0);
        check("t2_bubble_cnt", 32'(bubble_cnt), 1);

        // Squash beats gen_bubble (fetch word held)
        step("t3", 1, 1, 0, 0, 0);

        // Squash during a 3-cycle data stall
        step("t4a", 0, 1, 1, 1, 0);
        step("t4b", 0, 0, 1, 0, 0);
        step("t4c", 0, 0, 1, 0, 0);
        step("t4d", 0, 0, 1, 0, 1);
        check("t4_stall_cnt", 32'(stall_cnt), 3);

        // Fetch completes inside a data stall
        step("t5a", 0, 0, 1, 0, 0);
        step("t5b", 0, 0, 1, 1, 0);
        step("t5c", 0, 0, 1, 0, 0);
        step("t5d", 0, 0, 1, 0, 1);
        step("t5e", 0, 0, 0, 1, 1);

        // Narrow bubble counter saturation
        async_reset("t6r");
        step("t6a", 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("t6b", 1, 0, 0, 0, 0);
        check("t6_bubble_n", 32'(n_bubble_cnt), 3);
        check("t6_bubble", 32'(bubble_cnt), 5);

        for (int i = 0; i < 400; i++) begin
            bit dreq;
            if ($urandom_range(63) == 0) async_reset("rnd_rst");
            dreq = ($urandom_range(2) == 0);
            step("rnd", $urandom_range(3) == 0, $urandom_range(4) == 0, dreq,
                 !m_held && ($urandom_range(1) == 0), dreq && ($urandom_range(2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
